// File: rtl/dcache_arbiter_if.sv
// dcache_arbiter_if: bundles the two master request/ack ports and the
// dcache pin group shared by dcache_arbiter and its surroundings.
// slave  : the arbiter's view (takes requests, drives acks and dcache pins)
// master : the environment's view (masters plus the dcache itself)
interface dcache_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [1:0]    gnt;

  logic          dc_we;
  logic          dc_re;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [DW-1:0] dc_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  dc_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output gnt,
    output dc_we, dc_re, dc_addr, dc_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output dc_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  gnt,
    input  dc_we, dc_re, dc_addr, dc_wdata
  );
endinterface

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: shares the single-ported dcache word RAM between the CPU
// load/store unit (port 0) and a second bus master (port 1). One transaction
// takes IDLE -> ACCESS -> DONE; the dcache pins are active only in ACCESS.
//
// Build option: define DCACHE_ARB_RR_EN for round-robin tie breaking using a
// 1-bit last-winner pointer; otherwise port 0 always wins a tie.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request; winner's we/addr/wdata captured on grant
// ACCESS | dcache pins driven from the captured registers for one cycle
// DONE   | winner's ack pulses, gnt held, requests ignored
module dcache_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic            clk,
  input logic            reset,
  dcache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          grant;
  logic          winner;
  logic          owner_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] m0_rdata_r;
  logic [DW-1:0] m1_rdata_r;
  logic          in_access;
  logic          in_done;

`ifdef DCACHE_ARB_RR_EN
  logic last_r;

  // last-winner pointer; the port not granted last wins the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last_r <= 1'b0;
    else if (grant) last_r <= winner;
  end

  // round-robin pick; a single requester always wins
  always_comb begin
    winner = bus.m1_req;
    if (bus.m0_req && bus.m1_req) winner = ~last_r;
  end
`else
  // fixed priority pick: port 0 whenever it is requesting
  always_comb begin
    winner = ~bus.m0_req;
  end
`endif

  // state register; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant   = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // capture the winner's request so later input changes cannot disturb it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (grant) begin
      owner_r <= winner;
      we_r    <= winner ? bus.m1_we    : bus.m0_we;
      addr_r  <= winner ? bus.m1_addr  : bus.m0_addr;
      wdata_r <= winner ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  // read data lands in the owner's register at the ACCESS->DONE edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata_r <= '0;
      m1_rdata_r <= '0;
    end else if (in_access && !we_r) begin
      if (owner_r) m1_rdata_r <= bus.dc_rdata;
      else         m0_rdata_r <= bus.dc_rdata;
    end
  end

  // all outputs decode from state so reset clears them without waiting a clock
  assign in_access = (state == ACCESS);
  assign in_done   = (state == DONE);

  assign bus.dc_we    = in_access & we_r;
  assign bus.dc_re    = in_access & ~we_r;
  assign bus.dc_addr  = in_access ? addr_r  : '0;
  assign bus.dc_wdata = in_access ? wdata_r : '0;

  assign bus.gnt      = (in_access || in_done) ? {owner_r, ~owner_r} : 2'b00;
  assign bus.m0_ack   = in_done & ~owner_r;
  assign bus.m1_ack   = in_done &  owner_r;
  assign bus.m0_rdata = m0_rdata_r;
  assign bus.m1_rdata = m1_rdata_r;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter with a behavioural dcache word RAM.
// Inputs change at the falling edge; outputs are sampled at the falling edge.
module tb_dcache_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  dcache_arbiter_if #(.AW(32), .DW(32)) bus ();

  dcache_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // dcache model: combinational read, write commits on the rising edge
  logic [31:0] mem [0:255];
  assign bus.dc_rdata = mem[bus.dc_addr[9:2]];
  always @(posedge clk) begin
    if (bus.dc_we) mem[bus.dc_addr[9:2]] = bus.dc_wdata;
  end

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.gnt, bus.m0_ack, bus.m1_ack, bus.dc_we, bus.dc_re} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.gnt, bus.m0_ack, bus.m1_ack, bus.dc_we, bus.dc_re});
    end
    tests_run++;
    if ({bus.dc_addr, bus.dc_wdata, bus.m0_rdata, bus.m1_rdata} !== 128'b0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 0",
               {bus.dc_addr, bus.dc_wdata, bus.m0_rdata, bus.m1_rdata});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // {dc_re, dc_we, gnt[1:0], m0_ack, m1_ack}
  task automatic test_read0();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0;
    @(negedge clk);
    tests_run++;
    if ({bus.dc_re, bus.dc_we, bus.gnt, bus.m0_ack, bus.m1_ack} !== 6'b100100) begin
      tests_failed++;
      $display("FAIL read0_access: got %b expected 100100",
               {bus.dc_re, bus.dc_we, bus.gnt, bus.m0_ack, bus.m1_ack});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.dc_re, bus.dc_we, bus.gnt, bus.m0_ack, bus.m1_ack} !== 6'b000110) begin
      tests_failed++;
      $display("FAIL read0_done: got %b expected 000110",
               {bus.dc_re, bus.dc_we, bus.gnt, bus.m0_ack, bus.m1_ack});
    end
    tests_run++;
    if (bus.m0_rdata !== 32'h3243f6a8) begin
      tests_failed++;
      $display("FAIL read0_data: got %h expected 3243f6a8", bus.m0_rdata);
    end
    bus.m0_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.dc_re, bus.dc_we, bus.gnt, bus.m0_ack, bus.m1_ack} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL read0_idle: got %b expected 000000",
               {bus.dc_re, bus.dc_we, bus.gnt, bus.m0_ack, bus.m1_ack});
    end
  endtask

  task automatic test_write_read();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h148; bus.m1_wdata = 32'hdeadbeef;
    @(negedge clk);
    tests_run++;
    if ({bus.dc_re, bus.dc_we, bus.gnt, bus.m0_ack, bus.m1_ack} !== 6'b011000) begin
      tests_failed++;
      $display("FAIL write_access: got %b expected 011000",
               {bus.dc_re, bus.dc_we, bus.gnt, bus.m0_ack, bus.m1_ack});
    end
    tests_run++;
    if ({bus.dc_addr, bus.dc_wdata} !== {32'h148, 32'hdeadbeef}) begin
      tests_failed++;
      $display("FAIL write_pins: got %h expected 00000148deadbeef", {bus.dc_addr, bus.dc_wdata});
    end
    bus.m1_wdata = 32'h0;
    @(negedge clk);
    tests_run++;
    if ({bus.dc_we, bus.m1_ack, bus.m1_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL write_done: got we=%b ack=%b rdata=%h expected we=0 ack=1 rdata=0",
               bus.dc_we, bus.m1_ack, bus.m1_rdata);
    end
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h148;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.m0_ack, bus.m0_rdata, bus.m1_rdata} !== {1'b1, 32'hdeadbeef, 32'h0}) begin
      tests_failed++;
      $display("FAIL raw_read: got ack=%b m0=%h m1=%h expected ack=1 m0=deadbeef m1=0",
               bus.m0_ack, bus.m0_rdata, bus.m1_rdata);
    end
    bus.m0_req = 1'b0;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'hc; bus.m0_wdata = 32'h0badf00d;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.m0_ack, bus.m0_rdata} !== {1'b1, 32'hdeadbeef}) begin
      tests_failed++;
      $display("FAIL write_keeps_rdata: got ack=%b m0=%h expected ack=1 m0=deadbeef",
               bus.m0_ack, bus.m0_rdata);
    end
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int ack_port [2];
    int ack_cyc  [2];
    int n = 0;
    int first_port;
    ack_port = '{-1, -1};
    ack_cyc  = '{-1, -1};
`ifdef DCACHE_ARB_RR_EN
    first_port = 1;
`else
    first_port = 0;
`endif
    pulse_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h8;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h4;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (bus.m0_ack && n < 2) begin ack_port[n] = 0; ack_cyc[n] = cyc; n++; bus.m0_req = 1'b0; end
      if (bus.m1_ack && n < 2) begin ack_port[n] = 1; ack_cyc[n] = cyc; n++; bus.m1_req = 1'b0; end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tests_run++;
    if (n !== 2) begin
      tests_failed++;
      $display("FAIL tie_ack_count: got %0d expected 2", n);
    end
    tests_run++;
    if ({ack_port[0], ack_port[1]} !== {first_port, 1 - first_port}) begin
      tests_failed++;
      $display("FAIL tie_order: got %0d,%0d expected %0d,%0d",
               ack_port[0], ack_port[1], first_port, 1 - first_port);
    end
    tests_run++;
    if ({ack_cyc[0], ack_cyc[1]} !== {32'd2, 32'd5}) begin
      tests_failed++;
      $display("FAIL tie_timing: got %0d,%0d expected 2,5", ack_cyc[0], ack_cyc[1]);
    end
    tests_run++;
    if ({bus.m0_rdata, bus.m1_rdata} !== {32'h313198a2, 32'h885a308d}) begin
      tests_failed++;
      $display("FAIL tie_data: got m0=%h m1=%h expected m0=313198a2 m1=885a308d",
               bus.m0_rdata, bus.m1_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int ack_port [4];
    int ack_cyc  [4];
    int exp_port [4];
    int n = 0;
    ack_port = '{-1, -1, -1, -1};
    ack_cyc  = '{-1, -1, -1, -1};
`ifdef DCACHE_ARB_RR_EN
    exp_port = '{1, 0, 1, 0};
`else
    exp_port = '{0, 0, 0, 0};
`endif
    pulse_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h4;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.m0_ack && n < 4) begin ack_port[n] = 0; ack_cyc[n] = cyc; n++; end
      if (bus.m1_ack && n < 4) begin ack_port[n] = 1; ack_cyc[n] = cyc; n++; end
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL b2b_ack_count: got %0d expected 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ack_port[i] !== exp_port[i] || ack_cyc[i] !== 2 + 3 * i) begin
        tests_failed++;
        $display("FAIL b2b_ack%0d: got port %0d cycle %0d expected port %0d cycle %0d",
                 i, ack_port[i], ack_cyc[i], exp_port[i], 2 + 3 * i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic saw_ack = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h12345678;
    @(posedge clk);
    #2;
    tests_run++;
    if ({bus.gnt, bus.dc_we} !== 3'b011) begin
      tests_failed++;
      $display("FAIL rstmid_in_access: got gnt=%b we=%b expected gnt=01 we=1", bus.gnt, bus.dc_we);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.gnt, bus.m0_ack, bus.m1_ack, bus.dc_we, bus.dc_re} !== 6'b0) begin
      tests_failed++;
      $display("FAIL rstmid_ctrl: got %b expected 000000",
               {bus.gnt, bus.m0_ack, bus.m1_ack, bus.dc_we, bus.dc_re});
    end
    tests_run++;
    if ({bus.dc_addr, bus.dc_wdata, bus.m0_rdata, bus.m1_rdata} !== 128'b0) begin
      tests_failed++;
      $display("FAIL rstmid_data: got %h expected 0",
               {bus.dc_addr, bus.dc_wdata, bus.m0_rdata, bus.m1_rdata});
    end
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (bus.m0_ack || bus.m1_ack) saw_ack = 1'b1;
    end
    tests_run++;
    if (saw_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_no_ack: got ack seen=%b expected 0", saw_ack);
    end
    bus.m0_req = 1'b1; bus.m0_addr = 32'h0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.m0_ack, bus.m0_rdata} !== {1'b1, 32'h3243f6a8}) begin
      tests_failed++;
      $display("FAIL rstmid_no_commit: got ack=%b m0=%h expected ack=1 m0=3243f6a8",
               bus.m0_ack, bus.m0_rdata);
    end
    bus.m0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_change();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h4;
    @(posedge clk);
    #1;
    bus.m0_addr = 32'h8;
    @(negedge clk);
    tests_run++;
    if (bus.dc_addr !== 32'h4) begin
      tests_failed++;
      $display("FAIL addr_hold: got %h expected 00000004", bus.dc_addr);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.m0_ack, bus.m0_rdata} !== {1'b1, 32'h885a308d}) begin
      tests_failed++;
      $display("FAIL addr_hold_data: got ack=%b m0=%h expected ack=1 m0=885a308d",
               bus.m0_ack, bus.m0_rdata);
    end
    bus.m0_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h3243f6a8;
    mem[1] = 32'h885a308d;
    mem[2] = 32'h313198a2;
    reset = 1'b1;
    test_reset();
    test_read0();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_addr_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
